// File: rtl/ws2811_driver_if.sv
// rtl/ws2811_driver_if.sv - colour request / serial output bundle for ws2811_driver
interface ws2811_driver_if;
   logic       enable;
   logic [7:0] red;
   logic [7:0] green;
   logic [7:0] blue;
   logic [7:0] ledindex;
   logic       dout;
   logic       busy;
   logic       frame_done;

   modport master (
      input  enable, red, green, blue,
      output ledindex, dout, busy, frame_done
   );

   modport slave (
      output enable, red, green, blue,
      input  ledindex, dout, busy, frame_done
   );
endinterface

// File: rtl/ws2811_driver.sv
// rtl/ws2811_driver.sv - WS2811 single-wire serialiser fed by ledcontroller colour lookups
// Define WS2811_GRB_ORDER_EN to send green, red, blue instead of red, green, blue.
module ws2811_driver #(
   parameter int NUM_LEDS      = 49,
   parameter int T0H_CYCLES    = 13,
   parameter int T1H_CYCLES    = 30,
   parameter int BIT_CYCLES    = 63,
   parameter int SETTLE_CYCLES = 16,
   parameter int RESET_CYCLES  = 3000
) (
   input logic           clk,
   input logic           rst_n,
   ws2811_driver_if.master bus
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int PW = (BIT_CYCLES > 1)    ? $clog2(BIT_CYCLES)    : 1;
   localparam int RW = (RESET_CYCLES > 1)  ? $clog2(RESET_CYCLES)  : 1;

   localparam logic [7:0]    LAST_IDX   = 8'(NUM_LEDS - 1);
   localparam logic [SW-1:0] SETTLE_END = SW'(SETTLE_CYCLES - 1);
   localparam logic [PW-1:0] BIT_END    = PW'(BIT_CYCLES - 1);
   localparam logic [PW-1:0] T0H_END    = PW'(T0H_CYCLES - 1);
   localparam logic [PW-1:0] T1H_END    = PW'(T1H_CYCLES - 1);
   localparam logic [RW-1:0] RESET_END  = RW'(RESET_CYCLES - 1);

   if (!(T0H_CYCLES > 0 && T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
      $error("ws2811_driver: require 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
   end
   if (NUM_LEDS < 1 || NUM_LEDS > 256) begin : g_bad_leds
      $error("ws2811_driver: NUM_LEDS must be 1..256");
   end
   if (SETTLE_CYCLES < 1 || RESET_CYCLES < 1) begin : g_bad_waits
      $error("ws2811_driver: SETTLE_CYCLES and RESET_CYCLES must be at least 1");
   end

   typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_t;

   state_t        state;
   logic [SW-1:0] settle_cnt;
   logic [PW-1:0] phase_cnt;
   logic [RW-1:0] latch_cnt;
   logic [4:0]    bit_cnt;
   logic [23:0]   shift_reg;
   logic          last_led;
   logic [7:0]    ledindex_q;
   logic          dout_q;
   logic          busy_q;
   logic          frame_done_q;
   logic [23:0]   colour_word;
   logic [PW-1:0] high_end;

`ifdef WS2811_GRB_ORDER_EN
   assign colour_word = {bus.green, bus.red, bus.blue};
`else
   assign colour_word = {bus.red, bus.green, bus.blue};
`endif

   assign high_end = shift_reg[23] ? T1H_END : T0H_END;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         phase_cnt    <= '0;
         latch_cnt    <= '0;
         bit_cnt      <= '0;
         shift_reg    <= '0;
         last_led     <= 1'b0;
         ledindex_q   <= '0;
         dout_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state)
            IDLE: begin
               dout_q     <= 1'b0;
               ledindex_q <= '0;
               if (bus.enable) begin
                  state      <= FETCH;
                  busy_q     <= 1'b1;
                  settle_cnt <= '0;
               end
            end

            FETCH: begin
               if (settle_cnt == SETTLE_END) begin
                  shift_reg <= colour_word;
                  bit_cnt   <= 5'd23;
                  phase_cnt <= '0;
                  dout_q    <= 1'b1;
                  last_led  <= (ledindex_q == LAST_IDX);
                  if (ledindex_q != LAST_IDX) ledindex_q <= ledindex_q + 8'd1;
                  state     <= SHIFT;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end

            SHIFT: begin
               if (phase_cnt == BIT_END) begin
                  phase_cnt <= '0;
                  if (bit_cnt != 5'd0) begin
                     bit_cnt   <= bit_cnt - 5'd1;
                     shift_reg <= {shift_reg[22:0], 1'b0};
                     dout_q    <= 1'b1;
                  end else if (last_led) begin
                     state      <= LATCH;
                     ledindex_q <= '0;
                     dout_q     <= 1'b0;
                     latch_cnt  <= '0;
                  end else begin
                     // Next LED starts on this edge so the stream stays gapless.
                     shift_reg <= colour_word;
                     bit_cnt   <= 5'd23;
                     dout_q    <= 1'b1;
                     last_led  <= (ledindex_q == LAST_IDX);
                     if (ledindex_q != LAST_IDX) ledindex_q <= ledindex_q + 8'd1;
                  end
               end else begin
                  phase_cnt <= phase_cnt + 1'b1;
                  if (phase_cnt == high_end) dout_q <= 1'b0;
               end
            end

            LATCH: begin
               dout_q <= 1'b0;
               if (latch_cnt == RESET_END) begin
                  frame_done_q <= 1'b1;
                  latch_cnt    <= '0;
                  if (bus.enable) begin
                     state      <= FETCH;
                     settle_cnt <= '0;
                  end else begin
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end
               end else begin
                  latch_cnt <= latch_cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ledindex   = ledindex_q;
   assign bus.dout       = dout_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2811_driver.sv
// tb/tb_ws2811_driver.sv - directed bench for ws2811_driver with a latency-8 colour stub and pulse decoder
module tb_ws2811_driver;

   localparam int NL    = 4;
   localparam int T0H   = 13;
   localparam int T1H   = 30;
   localparam int BITC  = 63;
   localparam int SET   = 16;
   localparam int RST   = 3000;
   localparam int FLEN  = SET + NL * 24 * BITC + RST;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   ws2811_driver_if bus ();

   ws2811_driver #(
      .NUM_LEDS(NL), .T0H_CYCLES(T0H), .T1H_CYCLES(T1H),
      .BIT_CYCLES(BITC), .SETTLE_CYCLES(SET), .RESET_CYCLES(RST)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  r, g, b;
      logic [23:0] exp_rgb, exp_grb;
   } vec_t;

   vec_t tbl [8];
   int   base = 0;
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [23:0] exp_of(int i);
`ifdef WS2811_GRB_ORDER_EN
      return tbl[i].exp_grb;
`else
      return tbl[i].exp_rgb;
`endif
   endfunction

   // Stub ledcontroller: colour follows ledindex after 8 cycles.
   logic [7:0] pipe [8];
   initial for (int i = 0; i < 8; i++) pipe[i] = 8'd0;
   always @(negedge clk) begin
      for (int i = 7; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = bus.ledindex;
      bus.red   = tbl[base + int'(pipe[7][1:0])].r;
      bus.green = tbl[base + int'(pipe[7][1:0])].g;
      bus.blue  = tbl[base + int'(pipe[7][1:0])].b;
   end

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   logic [23:0] words [$];
   int          fd_cyc [$];
   logic        prev_dout = 1'b0, prev_busy = 1'b0;
   logic [23:0] sh = '0;
   int high_len = 0, nbits = 0, frame_rises = 0, last_rise = 0;
   int rises = 0, pulse_err = 0, period_err = 0;
   int first_rise_cyc = 0, busy_rise_cyc = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_dout = 1'b0; prev_busy = 1'b0;
         high_len = 0; nbits = 0; frame_rises = 0;
      end else begin
         if (bus.dout && !prev_dout) begin
            rises++;
            if (frame_rises > 0 && cyc - last_rise != BITC) period_err++;
            if (frame_rises == 0) first_rise_cyc = cyc;
            frame_rises++;
            last_rise = cyc;
            high_len = 0;
         end
         if (bus.dout) high_len++;
         if (!bus.dout && prev_dout) begin
            if (high_len == T0H)      sh = {sh[22:0], 1'b0};
            else if (high_len == T1H) sh = {sh[22:0], 1'b1};
            else                      pulse_err++;
            nbits++;
            if (nbits == 24) begin
               words.push_back(sh);
               nbits = 0;
            end
         end
         if (bus.busy && !prev_busy) begin
            busy_rise_cyc = cyc;
            frame_rises = 0;
         end
         if (bus.frame_done) begin
            fd_cyc.push_back(cyc);
            frame_rises = 0;
         end
         prev_dout = bus.dout;
         prev_busy = bus.busy;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_fd(input string name);
      int n0;
      int t;
      n0 = fd_cyc.size();
      t = 0;
      while (fd_cyc.size() == n0 && t < FLEN + 1000) begin
         tick();
         t++;
      end
      if (fd_cyc.size() == n0) begin
         n_vec++;
         n_bad++;
         $display("FAIL %s: frame_done timeout after %0d cycles", name, t);
      end
   endtask

   task automatic chk_words(input string name, input int off, input int b);
      for (int k = 0; k < NL; k++) begin
         if (off + k < words.size())
            chk($sformatf("%s led%0d", name, k), 32'(words[off+k]), 32'(exp_of(b + k)));
         else
            chk($sformatf("%s led%0d missing", name, k), 32'(words.size()), 32'(off + k + 1));
      end
   endtask

   initial begin
      int r0, t;
      tbl[0] = '{8'hA5, 8'h3C, 8'h0F, 24'hA53C0F, 24'h3CA50F};
      tbl[1] = '{8'h00, 8'hFF, 8'h00, 24'h00FF00, 24'hFF0000};
      tbl[2] = '{8'hFF, 8'h00, 8'h81, 24'hFF0081, 24'h00FF81};
      tbl[3] = '{8'h12, 8'h34, 8'h56, 24'h123456, 24'h341256};
      tbl[4] = '{8'h00, 8'h00, 8'h00, 24'h000000, 24'h000000};
      tbl[5] = '{8'h01, 8'h01, 8'h01, 24'h010101, 24'h010101};
      tbl[6] = '{8'h02, 8'h02, 8'h02, 24'h020202, 24'h020202};
      tbl[7] = '{8'h03, 8'h03, 8'h03, 24'h030303, 24'h030303};
      bus.enable = 1'b0;
      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset dout", 32'(bus.dout), 32'd0);
      chk("reset ledindex", 32'(bus.ledindex), 32'd0);
      chk("reset busy", 32'(bus.busy), 32'd0);
      chk("reset frame_done", 32'(bus.frame_done), 32'd0);
      rst_n = 1'b1;
      repeat (20) tick();

      // Frame A: enable pulsed for one edge; frame must still complete.
      base = 0;
      words.delete();
      fd_cyc.delete();
      bus.enable = 1'b1;
      t = 0;
      while (!bus.busy && t < 10) begin tick(); t++; end
      bus.enable = 1'b0;
      wait_fd("frameA");
      chk_words("frameA", 0, 0);
      chk("frameA length", 32'(fd_cyc[fd_cyc.size()-1] - busy_rise_cyc), 32'(FLEN));
      chk("frameA first rise", 32'(first_rise_cyc - busy_rise_cyc), 32'(SET));
      chk("frameA busy after", 32'(bus.busy), 32'd0);
      r0 = rises;
      repeat (300) tick();
      chk("frameA idle quiet", 32'(rises), 32'(r0));
      chk("frameA idle ledindex", 32'(bus.ledindex), 32'd0);

      // Frame B: index-pattern colours, enable dropped during LED 2.
      base = 4;
      words.delete();
      bus.enable = 1'b1;
      t = 0;
      while (bus.ledindex != 8'd3 && t < FLEN) begin tick(); t++; end
      chk("frameB reached led2", 32'(bus.ledindex), 32'd3);
      bus.enable = 1'b0;
      wait_fd("frameB");
      chk_words("frameB", 0, 4);
      chk("frameB length", 32'(fd_cyc[fd_cyc.size()-1] - busy_rise_cyc), 32'(FLEN));
      chk("frameB busy after", 32'(bus.busy), 32'd0);
      r0 = rises;
      repeat (300) tick();
      chk("frameB idle quiet", 32'(rises), 32'(r0));

      // Reset asserted in the middle of a high pulse.
      base = 0;
      bus.enable = 1'b1;
      repeat (500) tick();
      t = 0;
      while (!bus.dout && t < 200) begin tick(); t++; end
      chk("pre-reset dout high", 32'(bus.dout), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async reset dout", 32'(bus.dout), 32'd0);
      chk("async reset ledindex", 32'(bus.ledindex), 32'd0);
      chk("async reset busy", 32'(bus.busy), 32'd0);
      repeat (3) tick();
      words.delete();
      fd_cyc.delete();
      rst_n = 1'b1;

      // Three back-to-back frames with enable held high.
      wait_fd("b2b frame1");
      if (fd_cyc.size() > 0)
         chk("b2b first length", 32'(fd_cyc[0] - busy_rise_cyc), 32'(FLEN));
      wait_fd("b2b frame2");
      bus.enable = 1'b0;
      wait_fd("b2b frame3");
      for (int f = 0; f < 3; f++) chk_words($sformatf("b2b f%0d", f), f * NL, 0);
      chk("b2b frame_done count", 32'(fd_cyc.size()), 32'd3);
      if (fd_cyc.size() >= 3) begin
         chk("b2b spacing 1-2", 32'(fd_cyc[1] - fd_cyc[0]), 32'(FLEN));
         chk("b2b spacing 2-3", 32'(fd_cyc[2] - fd_cyc[1]), 32'(FLEN));
      end
      chk("b2b busy after", 32'(bus.busy), 32'd0);
      chk("pulse widths", 32'(pulse_err), 32'd0);
      chk("bit periods", 32'(period_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
